fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Instruction-fetch PC generator sitting directly upstream of the instruction memory in the pipeline.
- Owns the architectural fetch PC and drives the memory's PC, flush and hold inputs.
- The instruction memory registers its output one cycle after the PC. This block therefore also produces the matching delayed PC, PC+4 and a valid flag for the decode stage.
- Handles hazard hold, branch/jump redirect, a boot settle period and a sticky misaligned-target fault.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- BOOT_CYCLES, 1, cycles spent in BOOT (flush held, PC frozen) after reset; legal range 1..15.

Ports:
- Clock in 1 system clock, all state on posedge.
- Reset in 1 synchronous, active-high reset.
- hold_in in 1 hazard-unit stall request.
- redirect_valid in 1 branch/jump taken this cycle.
- redirect_target in 32 new fetch address.
- PC out 32 fetch address to instruction memory; equals pc_q.
- flush out 1 squash to instruction memory (memory loads NOP 32'h00000013).
- hold out 1 stall to instruction memory; equals hold_in while in RUN, else 0.
- if_pc out 32 address of the instruction currently on the memory output.
- if_pc_plus4 out 32 if_pc + 4, mod 2^32.
- if_valid out 1 memory output is a real instruction, not an injected NOP.
- misalign_fault out 1 sticky fault flag.
- perf_fetch_cnt out 32 feature counter (see Optional Feature).
- perf_hold_cnt out 32 feature counter.
- perf_redirect_cnt out 32 feature counter.

Behaviour:
- State enum: BOOT, RUN, FAULT.
- Reset (any cycle, overrides everything):
  - pc_q = RESET_VECTOR, state = BOOT, boot_cnt = BOOT_CYCLES-1.
  - if_pc = 0, if_valid = 0, misalign_fault = 0, all perf counters = 0.
- Outputs in BOOT:
  - flush = 1, hold = 0, pc_q frozen.
  - boot_cnt decrements each cycle; at 0 -> RUN next edge.
  - redirect_valid ignored.
- RUN, next-PC priority:
  - redirect_valid with redirect_target[1:0] != 0: pc_q frozen, state -> FAULT, misalign_fault = 1.
  - redirect_valid with aligned target: pc_q <= redirect_target.
  - hold_in: pc_q holds.
  - otherwise: pc_q <= pc_q + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- flush in RUN = redirect_valid, combinational same cycle, so the wrong-path fetch becomes a NOP. Redirect during hold: redirect wins, flush = 1.
- FAULT: flush = 1, hold = 0, PC frozen, misalign_fault stays 1; exit only via Reset.
- Alignment pipeline, every non-reset edge:
  - if_pc <= pc_q, if_pc_plus4 is combinational from if_pc.
  - if_valid <= (state == RUN) && !flush && !hold_in.
  - Latency PC -> if_pc/if_valid is exactly 1 cycle, matching the memory.
- if_pc still updates under hold. The paired instruction is a NOP, so if_valid = 0.
- No combinational path from redirect_target to PC; PC is always a register output.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined:
  - perf_fetch_cnt increments when if_valid is set next edge.
  - perf_hold_cnt increments on RUN && hold_in && !redirect_valid.
  - perf_redirect_cnt increments on each accepted aligned redirect.
  - All 32-bit wrapping, cleared by Reset.
- Undefined: the counter registers are not built and the three ports are tied to 32'h0.

Decomposition:
- Shared package pipeline_pkg:
  - fetch_state_e enum (BOOT/RUN/FAULT).
  - NOP_INSTR = 32'h00000013.
  - INSTR_BYTES = 4.
- One natural sub-module: fetch_perf_counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset with RESET_VECTOR=0, BOOT_CYCLES=1 -> flush=1 for one cycle. PC then steps 0,4,8. if_pc trails PC by one cycle; if_valid=1 from the first post-BOOT fetch.
- Hold for 3 cycles at PC=8 -> PC stays 8, if_valid=0 for 3 cycles. PC resumes at 12, no address skipped.
- Redirect to 0x40 at PC=0x10 -> flush=1 that cycle, next PC=0x40, if_valid=0 for the 0x10 slot. if_pc=0x40 with if_valid=1 one cycle later.
- Redirect to 0x40 and hold in the same cycle -> redirect taken, PC=0x40, flush=1.
- Redirect to 0x42 -> misalign_fault=1, PC frozen, flush held 1 for 10 cycles. Reset clears everything and reboots to RESET_VECTOR.
- Wrap at PC=32'hFFFF_FFFC -> next PC=0, if_pc_plus4=0. With FETCH_PERF_EN over 10 fetches, 3 holds and 1 redirect -> counters read 10, 3 and 1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared fetch-pipeline types and constants.
// Contents: fetch FSM state enum, injected NOP encoding, instruction size.
package pipeline_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch performance counters: fetched, held and redirected slots.
// Ports: clk, rst (sync, active-high), three increment strobes, three 32-bit counts.
// Built only when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc,
  input  logic        hold_inc,
  input  logic        redirect_inc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] hold_cnt,
  output logic [31:0] redirect_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt    <= '0;
      hold_cnt     <= '0;
      redirect_cnt <= '0;
    end else begin
      if (fetch_inc)    fetch_cnt    <= fetch_cnt + 32'd1;
      if (hold_inc)     hold_cnt     <= hold_cnt + 32'd1;
      if (redirect_inc) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: owns the fetch PC, drives imem PC/flush/hold and
// the one-cycle-delayed if_pc/if_pc_plus4/if_valid for decode.
// Ports: Clock, Reset (sync, active-high), hold_in, redirect_valid,
// redirect_target in; PC, flush, hold, if_pc, if_pc_plus4, if_valid,
// misalign_fault, perf_fetch_cnt, perf_hold_cnt, perf_redirect_cnt out.
// Optional counters: define FETCH_PERF_EN, otherwise perf ports read 0.
module fetch_pc_gen
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned BOOT_CYCLES  = 1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        hold_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] PC,
  output logic        flush,
  output logic        hold,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        if_valid,
  output logic        misalign_fault,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_hold_cnt,
  output logic [31:0] perf_redirect_cnt
);

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [3:0]   boot_q, boot_d;
  logic         fault_q, fault_d;
  logic [31:0]  if_pc_q;
  logic         if_valid_q;
  logic         run;
  logic         aligned;
  logic         valid_next;

  assign run     = (state_q == RUN);
  assign aligned = (redirect_target[1:0] == 2'b00);

  // Outside RUN the memory is always squashed and never stalled.
  assign flush      = run ? redirect_valid : 1'b1;
  assign hold       = run & hold_in;
  assign valid_next = run & ~redirect_valid & ~hold_in;

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    boot_d  = boot_q;
    fault_d = fault_q;
    unique case (state_q)
      BOOT: begin
        if (boot_q == 4'd0) state_d = RUN;
        else                boot_d  = boot_q - 4'd1;
      end
      RUN: begin
        if (redirect_valid && !aligned) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (!hold_in) begin
          pc_d = pc_q + 32'(INSTR_BYTES);
        end
      end
      FAULT: ;
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q       <= RESET_VECTOR;
      state_q    <= BOOT;
      boot_q     <= BOOT_INIT;
      fault_q    <= 1'b0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      boot_q     <= boot_d;
      fault_q    <= fault_d;
      // Tracks the memory's registered output, including held slots.
      if_pc_q    <= pc_q;
      if_valid_q <= valid_next;
    end
  end

  assign PC             = pc_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_q + 32'(INSTR_BYTES);
  assign if_valid       = if_valid_q;
  assign misalign_fault = fault_q;

`ifdef FETCH_PERF_EN
  logic hold_inc;
  logic redirect_inc;

  assign hold_inc     = run & hold_in & ~redirect_valid;
  assign redirect_inc = run & redirect_valid & aligned;

  fetch_perf_counters u_perf (
    .clk          (Clock),
    .rst          (Reset),
    .fetch_inc    (valid_next),
    .hold_inc     (hold_inc),
    .redirect_inc (redirect_inc),
    .fetch_cnt    (perf_fetch_cnt),
    .hold_cnt     (perf_hold_cnt),
    .redirect_cnt (perf_redirect_cnt)
  );
`else
  assign perf_fetch_cnt    = '0;
  assign perf_hold_cnt     = '0;
  assign perf_redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Self-checking bench for fetch_pc_gen.
// Scoreboard of expected if_pc/if_valid plus per-scenario inline checks.
module tb_fetch_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam int unsigned BC = 1;

  logic        clk = 1'b0;
  logic        Reset = 1'b1;
  logic        hold_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [31:0] PC;
  logic        flush;
  logic        hold;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        if_valid;
  logic        misalign_fault;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_hold_cnt;
  logic [31:0] perf_redirect_cnt;

  fetch_pc_gen #(
    .RESET_VECTOR (RV),
    .BOOT_CYCLES  (BC)
  ) dut (
    .Clock             (clk),
    .Reset             (Reset),
    .hold_in           (hold_in),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .PC                (PC),
    .flush             (flush),
    .hold              (hold),
    .if_pc             (if_pc),
    .if_pc_plus4       (if_pc_plus4),
    .if_valid          (if_valid),
    .misalign_fault    (misalign_fault),
    .perf_fetch_cnt    (perf_fetch_cnt),
    .perf_hold_cnt     (perf_hold_cnt),
    .perf_redirect_cnt (perf_redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_pc;
  int          exp_fetch = 0;
  int          exp_hold = 0;
  int          exp_redir = 0;

  // Scoreboard: entry pushed in the cycle PC is presented,
  // checked right after the edge that moves it onto if_pc.
  always @(posedge clk) begin
    #1;
    if (Reset) begin
      sb.delete();
    end else if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      tests_run++;
      if (if_pc !== mon_e.pc) begin
        tests_failed++;
        $display("FAIL sb_if_pc: got %h want %h", if_pc, mon_e.pc);
      end
      tests_run++;
      if (if_valid !== mon_e.valid) begin
        tests_failed++;
        $display("FAIL sb_if_valid: got %b want %b (if_pc %h)",
                 if_valid, mon_e.valid, mon_e.pc);
      end
      tests_run++;
      if (if_pc_plus4 !== mon_e.pc + 32'd4) begin
        tests_failed++;
        $display("FAIL sb_if_pc_plus4: got %h want %h",
                 if_pc_plus4, mon_e.pc + 32'd4);
      end
    end
  end

  task automatic push(input logic [31:0] pc, input logic v);
    exp_t e;
    e.pc = pc;
    e.valid = v;
    sb.push_back(e);
    if (v) exp_fetch++;
  endtask

  task automatic drive(input logic h, input logic rv, input logic [31:0] t);
    @(negedge clk);
    Reset = 1'b0;
    hold_in = h;
    redirect_valid = rv;
    redirect_target = t;
    #1;
  endtask

  // Reset asserted with hold/redirect active to show it overrides them.
  task automatic do_reset();
    @(negedge clk);
    Reset = 1'b1;
    hold_in = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1;
    exp_fetch = 0;
    exp_hold = 0;
    exp_redir = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if (PC !== RV) begin
      tests_failed++; $display("FAIL rst_pc: got %h want %h", PC, RV);
    end
    tests_run++;
    if (flush !== 1'b1) begin
      tests_failed++; $display("FAIL rst_flush: got %b want 1", flush);
    end
    tests_run++;
    if (hold !== 1'b0) begin
      tests_failed++; $display("FAIL rst_hold: got %b want 0", hold);
    end
    tests_run++;
    if (if_pc !== 32'h0 || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_if: got %h/%b want 0/0", if_pc, if_valid);
    end
    tests_run++;
    if (misalign_fault !== 1'b0) begin
      tests_failed++; $display("FAIL rst_fault: got %b want 0", misalign_fault);
    end
    tests_run++;
    if (perf_fetch_cnt !== 0 || perf_hold_cnt !== 0 || perf_redirect_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rst_perf: got %0d/%0d/%0d want 0/0/0",
               perf_fetch_cnt, perf_hold_cnt, perf_redirect_cnt);
    end
    // BOOT cycle: hold and redirect must be ignored.
    drive(1'b1, 1'b1, 32'h0000_0100);
    tests_run++;
    if (PC !== RV || flush !== 1'b1 || hold !== 1'b0) begin
      tests_failed++;
      $display("FAIL boot: got pc %h flush %b hold %b want %h 1 0",
               PC, flush, hold, RV);
    end
    push(RV, 1'b0);
    exp_pc = RV;
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (PC !== exp_pc || flush !== 1'b0 || hold !== 1'b0) begin
        tests_failed++;
        $display("FAIL seq_pc: got %h f%b h%b want %h f0 h0",
                 PC, flush, hold, exp_pc);
      end
      push(exp_pc, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0);
      tests_run++;
      if (PC !== 32'h8 || hold !== 1'b1 || flush !== 1'b0) begin
        tests_failed++;
        $display("FAIL hold_pc: got %h h%b f%b want 00000008 h1 f0",
                 PC, hold, flush);
      end
      push(exp_pc, 1'b0);
      exp_hold++;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (PC !== exp_pc) begin
        tests_failed++;
        $display("FAIL hold_resume: got %h want %h", PC, exp_pc);
      end
      push(exp_pc, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_redirect();
    drive(1'b0, 1'b1, 32'h0000_0040);
    tests_run++;
    if (PC !== 32'h10 || flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL redir_cycle: got %h f%b want 00000010 f1", PC, flush);
    end
    push(exp_pc, 1'b0);
    exp_redir++;
    exp_pc = 32'h40;
    drive(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (PC !== 32'h40 || flush !== 1'b0) begin
      tests_failed++;
      $display("FAIL redir_target: got %h f%b want 00000040 f0", PC, flush);
    end
    push(exp_pc, 1'b1);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_redirect_hold();
    drive(1'b1, 1'b1, 32'h0000_0040);
    tests_run++;
    if (PC !== 32'h44 || flush !== 1'b1 || hold !== 1'b1) begin
      tests_failed++;
      $display("FAIL rh_cycle: got %h f%b h%b want 00000044 f1 h1",
               PC, flush, hold);
    end
    push(exp_pc, 1'b0);
    exp_redir++;
    exp_pc = 32'h40;
    drive(1'b0, 1'b0, 32'h0);
    tests_run++;
    if (PC !== 32'h40) begin
      tests_failed++;
      $display("FAIL rh_target: got %h want 00000040", PC);
    end
    push(exp_pc, 1'b1);
    exp_pc = exp_pc + 32'd4;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 32'hFFFF_FFF8);
    push(exp_pc, 1'b0);
    exp_redir++;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (PC !== exp_pc) begin
        tests_failed++;
        $display("FAIL wrap_pc: got %h want %h", PC, exp_pc);
      end
      push(exp_pc, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end
    tests_run++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0) begin
      tests_failed++;
      $display("FAIL wrap_plus4: got %h/%h want fffffffc/00000000",
               if_pc, if_pc_plus4);
    end
  endtask

  task automatic test_perf();
    @(negedge clk);
    #1;
`ifdef FETCH_PERF_EN
    tests_run++;
    if (perf_fetch_cnt !== 32'(exp_fetch)) begin
      tests_failed++;
      $display("FAIL perf_fetch: got %0d want %0d", perf_fetch_cnt, exp_fetch);
    end
    tests_run++;
    if (perf_hold_cnt !== 32'(exp_hold)) begin
      tests_failed++;
      $display("FAIL perf_hold: got %0d want %0d", perf_hold_cnt, exp_hold);
    end
    tests_run++;
    if (perf_redirect_cnt !== 32'(exp_redir)) begin
      tests_failed++;
      $display("FAIL perf_redir: got %0d want %0d", perf_redirect_cnt, exp_redir);
    end
`else
    tests_run++;
    if (perf_fetch_cnt !== 0 || perf_hold_cnt !== 0 || perf_redirect_cnt !== 0) begin
      tests_failed++;
      $display("FAIL perf_off: got %0d/%0d/%0d want 0/0/0",
               perf_fetch_cnt, perf_hold_cnt, perf_redirect_cnt);
    end
`endif
  endtask

  task automatic test_misalign();
    do_reset();
    drive(1'b0, 1'b0, 32'h0);
    push(RV, 1'b0);
    exp_pc = RV;
    drive(1'b0, 1'b0, 32'h0);
    push(exp_pc, 1'b1);
    exp_pc = exp_pc + 32'd4;
    drive(1'b0, 1'b1, 32'h0000_0042);
    tests_run++;
    if (PC !== exp_pc || flush !== 1'b1) begin
      tests_failed++;
      $display("FAIL mis_cycle: got %h f%b want %h f1", PC, flush, exp_pc);
    end
    push(exp_pc, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 1'b1, 32'h0000_0080);
      tests_run++;
      if (PC !== exp_pc || flush !== 1'b1 || hold !== 1'b0
          || misalign_fault !== 1'b1) begin
        tests_failed++;
        $display("FAIL mis_frozen: got %h f%b h%b m%b want %h f1 h0 m1",
                 PC, flush, hold, misalign_fault, exp_pc);
      end
      push(exp_pc, 1'b0);
    end
    do_reset();
    tests_run++;
    if (misalign_fault !== 1'b0 || PC !== RV || if_pc !== 32'h0
        || if_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mis_reset: got m%b %h %h v%b want m0 %h 0 v0",
               misalign_fault, PC, if_pc, if_valid, RV);
    end
    drive(1'b0, 1'b0, 32'h0);
    push(RV, 1'b0);
    exp_pc = RV;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (PC !== exp_pc || flush !== 1'b0) begin
        tests_failed++;
        $display("FAIL mis_reboot: got %h f%b want %h f0", PC, flush, exp_pc);
      end
      push(exp_pc, 1'b1);
      exp_pc = exp_pc + 32'd4;
    end
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_redirect();
    test_redirect_hold();
    test_wrap();
    test_perf();
    test_misalign();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
